// File: rtl/memctrl_pkg.sv
// memctrl_pkg: shared array geometry and the read-tag carried through the SRAM latency pipe
package memctrl_pkg;
  localparam int NUM_BANK    = 64;
  localparam int NUM_SPARE   = 25;
  localparam int DATA_W      = 8;
  localparam int BANK_SEL_W  = 6;
  localparam int SPARE_SEL_W = 5;

  typedef struct packed {
    logic                  vld;
    logic                  spare;
    logic                  bist;
    logic [BANK_SEL_W-1:0] sel;
  } rd_tag_t;
endpackage

// File: rtl/rdata_fifo.sv
// rdata_fifo: sync FIFO with registered head; drops pushes on full unless a pop frees a slot
module rdata_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  data_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   lvl_q;
  logic          do_push, do_pop;
  always_comb begin
    full_o  = lvl_q == (AW+1)'(DEPTH);
    empty_o = lvl_q == '0;
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    level_o = lvl_q;
    data_o  = empty_o ? '0 : mem_q[rd_q];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      lvl_q <= lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/mem_rdata_return.sv
// mem_rdata_return: tracks issued SRAM reads through RD_LAT cycles, muxes the addressed bank byte,
// and routes it to BIST_ODATA or the host return FIFO
module mem_rdata_return
  import memctrl_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RSTN,
  input  logic                          BIST_EN,
  input  logic                          MEM_CE,
  input  logic                          MEM_WEB,
  input  logic [NUM_BANK-1:0]           MEM_OEB,
  input  logic [NUM_BANK-1:0]           MEM_CSB,
  input  logic [BANK_SEL_W-1:0]         MEM_ODATA_SELECT,
  input  logic [NUM_BANK*DATA_W-1:0]    MEM_ODATA_BUS,
  input  logic                          SPARE_MEM_CE,
  input  logic                          SPARE_MEM_WEB,
  input  logic [NUM_SPARE-1:0]          SPARE_MEM_OEB,
  input  logic [NUM_SPARE-1:0]          SPARE_MEM_CSB,
  input  logic [SPARE_SEL_W-1:0]        SPARE_MEM_ODATA_SELECT,
  input  logic [NUM_SPARE*DATA_W-1:0]   SPARE_MEM_ODATA_BUS,
  output logic [DATA_W-1:0]             ODATA,
  output logic                          ODATA_VALID,
  input  logic                          ODATA_READY,
  output logic [DATA_W-1:0]             BIST_ODATA,
  output logic [4:0]                    FIFO_LEVEL,
  output logic                          OVERFLOW,
  output logic                          ERR_SEL
);
  localparam int SW = 1 << SPARE_SEL_W;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Out-of-range spare selects read as enabled so they issue and get flagged at capture
  logic [SW-1:0]        s_csb, s_oeb;
  logic [SW*DATA_W-1:0] s_bus;
  logic                 main_rd, spare_rd, bad_spare, push, pop, full, empty;
  rd_tag_t              tag_in, cap;
  rd_tag_t              tag_q [RD_LAT];
  logic [DATA_W-1:0]    cap_data, bist_d, bist_q;
  logic                 ovf_d, ovf_q, err_d, err_q;
  logic [LW-1:0]        lvl;

  always_comb begin
    s_csb     = {{(SW-NUM_SPARE){1'b0}}, SPARE_MEM_CSB};
    s_oeb     = {{(SW-NUM_SPARE){1'b0}}, SPARE_MEM_OEB};
    s_bus     = {{((SW-NUM_SPARE)*DATA_W){1'b0}}, SPARE_MEM_ODATA_BUS};
    main_rd   = MEM_CE & MEM_WEB & ~MEM_CSB[MEM_ODATA_SELECT] & ~MEM_OEB[MEM_ODATA_SELECT];
    spare_rd  = SPARE_MEM_CE & SPARE_MEM_WEB & ~s_csb[SPARE_MEM_ODATA_SELECT]
              & ~s_oeb[SPARE_MEM_ODATA_SELECT];
    tag_in    = {main_rd | spare_rd, ~main_rd, BIST_EN,
                 main_rd ? MEM_ODATA_SELECT : {1'b0, SPARE_MEM_ODATA_SELECT}};
    cap       = tag_q[RD_LAT-1];
    bad_spare = cap.vld & cap.spare & (cap.sel >= BANK_SEL_W'(NUM_SPARE));
    cap_data  = !cap.spare ? MEM_ODATA_BUS[{cap.sel, 3'b000} +: DATA_W]
              : bad_spare  ? '0 : s_bus[{cap.sel[SPARE_SEL_W-1:0], 3'b000} +: DATA_W];
    push      = cap.vld & ~cap.bist;
    pop       = ODATA_VALID & ODATA_READY;
    ovf_d     = ovf_q | (push & full & ~pop);
    err_d     = err_q | (main_rd & spare_rd) | bad_spare;
    bist_d    = (cap.vld & cap.bist) ? cap_data : bist_q;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
      bist_q <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
      bist_q <= bist_d;
      ovf_q  <= ovf_d;
      err_q  <= err_d;
    end
  end

  rdata_fifo #(.DEPTH(FIFO_DEPTH), .W(DATA_W)) u_fifo (
    .clk     (CLK),
    .rst_n   (RSTN),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (cap_data),
    .data_o  (ODATA),
    .full_o  (full),
    .empty_o (empty),
    .level_o (lvl)
  );

  always_comb begin
    ODATA_VALID = ~empty;
    FIFO_LEVEL  = 5'(lvl);
    BIST_ODATA  = bist_q;
    OVERFLOW    = ovf_q;
    ERR_SEL     = err_q;
  end
endmodule

// File: tb/tb_mem_rdata_return.sv
// tb_mem_rdata_return: scoreboard bench with a queue-based reference model of the read return path
module tb_mem_rdata_return;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 4;

  logic         CLK = 1'b0, RSTN = 1'b0;
  logic         BIST_EN, MEM_CE, MEM_WEB, SPARE_MEM_CE, SPARE_MEM_WEB, ODATA_READY;
  logic [63:0]  MEM_OEB, MEM_CSB;
  logic [5:0]   MEM_ODATA_SELECT;
  logic [511:0] MEM_ODATA_BUS;
  logic [24:0]  SPARE_MEM_OEB, SPARE_MEM_CSB;
  logic [4:0]   SPARE_MEM_ODATA_SELECT;
  logic [199:0] SPARE_MEM_ODATA_BUS;
  logic [7:0]   ODATA, BIST_ODATA;
  logic         ODATA_VALID, OVERFLOW, ERR_SEL;
  logic [4:0]   FIFO_LEVEL;

  logic [7:0] mbytes [64];
  logic [7:0] sbytes [25];

  typedef struct {int due; bit spare; bit bist; int sel;} rd_t;
  rd_t        pipe [$];
  logic [7:0] exp_q [$];
  int         cyc = 0, mlevel = 0;
  bit         movf = 0, merr = 0;
  logic [7:0] mbist = 8'h00;
  int         checks = 0, failures = 0;

  always #5 CLK = ~CLK;

  always_comb begin
    for (int k = 0; k < 64; k++) MEM_ODATA_BUS[8*k +: 8] = mbytes[k];
    for (int k = 0; k < 25; k++) SPARE_MEM_ODATA_BUS[8*k +: 8] = sbytes[k];
  end

  mem_rdata_return #(.RD_LAT(RD_LAT), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RSTN(RSTN), .BIST_EN(BIST_EN),
    .MEM_CE(MEM_CE), .MEM_WEB(MEM_WEB), .MEM_OEB(MEM_OEB), .MEM_CSB(MEM_CSB),
    .MEM_ODATA_SELECT(MEM_ODATA_SELECT), .MEM_ODATA_BUS(MEM_ODATA_BUS),
    .SPARE_MEM_CE(SPARE_MEM_CE), .SPARE_MEM_WEB(SPARE_MEM_WEB),
    .SPARE_MEM_OEB(SPARE_MEM_OEB), .SPARE_MEM_CSB(SPARE_MEM_CSB),
    .SPARE_MEM_ODATA_SELECT(SPARE_MEM_ODATA_SELECT), .SPARE_MEM_ODATA_BUS(SPARE_MEM_ODATA_BUS),
    .ODATA(ODATA), .ODATA_VALID(ODATA_VALID), .ODATA_READY(ODATA_READY),
    .BIST_ODATA(BIST_ODATA), .FIFO_LEVEL(FIFO_LEVEL), .OVERFLOW(OVERFLOW), .ERR_SEL(ERR_SEL)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: cycle %0d got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every host handshake must return the oldest outstanding expected byte
  always @(negedge CLK) begin
    if (RSTN && ODATA_VALID && ODATA_READY) begin
      if (exp_q.size() == 0) chk("odata_unexpected", {24'h0, ODATA}, 32'hFFFF_FFFF);
      else chk("odata", {24'h0, ODATA}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic model_step();
    bit pop, m, s;
    int lvl_n;
    rd_t r;
    logic [7:0] d;
    if (!RSTN) begin
      pipe.delete(); exp_q.delete();
      mlevel = 0; movf = 0; merr = 0; mbist = 8'h00;
      cyc++;
      return;
    end
    pop   = mlevel > 0 && ODATA_READY;
    lvl_n = mlevel - int'(pop);
    if (pipe.size() > 0 && pipe[0].due == cyc) begin
      r = pipe.pop_front();
      d = !r.spare ? mbytes[r.sel] : (r.sel >= 25 ? 8'h00 : sbytes[r.sel]);
      if (r.spare && r.sel >= 25) merr = 1;
      if (r.bist) mbist = d;
      else if (mlevel < DEPTH || pop) begin exp_q.push_back(d); lvl_n++; end
      else movf = 1;
    end
    m = MEM_CE && MEM_WEB && !MEM_CSB[MEM_ODATA_SELECT] && !MEM_OEB[MEM_ODATA_SELECT];
    s = SPARE_MEM_CE && SPARE_MEM_WEB && (SPARE_MEM_ODATA_SELECT >= 25 ||
        (!SPARE_MEM_CSB[SPARE_MEM_ODATA_SELECT] && !SPARE_MEM_OEB[SPARE_MEM_ODATA_SELECT]));
    if (m && s) merr = 1;
    if (m || s) begin
      r.due = cyc + RD_LAT; r.spare = !m; r.bist = BIST_EN;
      r.sel = m ? int'(MEM_ODATA_SELECT) : int'(SPARE_MEM_ODATA_SELECT);
      pipe.push_back(r);
    end
    mlevel = lvl_n;
    cyc++;
  endtask

  task automatic tick();
    model_step();
    @(posedge CLK);
    #2;
    chk("level", {27'h0, FIFO_LEVEL}, mlevel);
    chk("valid", {31'h0, ODATA_VALID}, {31'h0, mlevel > 0});
    chk("overflow", {31'h0, OVERFLOW}, {31'h0, movf});
    chk("err_sel", {31'h0, ERR_SEL}, {31'h0, merr});
    chk("bist_odata", {24'h0, BIST_ODATA}, {24'h0, mbist});
    if (!RSTN) chk("odata_rst", {24'h0, ODATA}, 0);
  endtask

  task automatic idle();
    MEM_CE = 0; SPARE_MEM_CE = 0; MEM_WEB = 1; SPARE_MEM_WEB = 1;
  endtask

  task automatic main_rd(input int sel);
    MEM_CE = 1; MEM_WEB = 1; MEM_ODATA_SELECT = 6'(sel); SPARE_MEM_CE = 0;
  endtask

  task automatic spare_rd(input int sel);
    SPARE_MEM_CE = 1; SPARE_MEM_WEB = 1; SPARE_MEM_ODATA_SELECT = 5'(sel); MEM_CE = 0;
  endtask

  initial begin
    BIST_EN = 0; MEM_OEB = '0; MEM_CSB = '0; SPARE_MEM_OEB = '0; SPARE_MEM_CSB = '0;
    MEM_ODATA_SELECT = '0; SPARE_MEM_ODATA_SELECT = '0; ODATA_READY = 1;
    for (int k = 0; k < 64; k++) mbytes[k] = 8'($urandom);
    for (int k = 0; k < 25; k++) sbytes[k] = 8'($urandom);
    idle();
    tick(); tick();
    RSTN = 1; tick();
    // main read of bank 5
    mbytes[5] = 8'hA5; main_rd(5); tick();
    idle(); repeat (3) tick();
    // spare 24 then illegal spare 27
    sbytes[24] = 8'h3C; spare_rd(24); tick();
    spare_rd(27); tick();
    idle(); repeat (3) tick();
    // BIST read of bank 63
    BIST_EN = 1; mbytes[63] = 8'h5A; main_rd(63); tick();
    idle(); tick();
    BIST_EN = 0; repeat (2) tick();
    // overflow with READY low, then drain
    ODATA_READY = 0;
    for (int i = 0; i < 6; i++) begin mbytes[i] = 8'(i + 1); main_rd(i); tick(); end
    idle(); tick();
    ODATA_READY = 1; repeat (6) tick();
    RSTN = 0; tick(); RSTN = 1; tick();
    // full FIFO with sustained push+pop
    ODATA_READY = 0;
    for (int i = 0; i < 4; i++) begin mbytes[10+i] = 8'(16 + i); main_rd(10 + i); tick(); end
    idle(); tick();
    ODATA_READY = 1;
    for (int i = 0; i < 6; i++) begin mbytes[20+i] = 8'(32 + i); main_rd(20 + i); tick(); end
    idle(); repeat (6) tick();
    // write cycle, then simultaneous main+spare
    MEM_CE = 1; MEM_WEB = 0; MEM_ODATA_SELECT = 6'd3; tick();
    main_rd(7); SPARE_MEM_CE = 1; SPARE_MEM_WEB = 1; SPARE_MEM_ODATA_SELECT = 5'd2; tick();
    idle(); repeat (3) tick();
    // reset mid-stream
    ODATA_READY = 0;
    for (int i = 0; i < 3; i++) begin main_rd(30 + i); tick(); end
    RSTN = 0; tick();
    RSTN = 1; idle(); ODATA_READY = 1; repeat (3) tick();
    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 64; k++) mbytes[k] = 8'($urandom);
      for (int k = 0; k < 25; k++) sbytes[k] = 8'($urandom);
      BIST_EN = ($urandom_range(0, 3) == 0);
      MEM_CE = ($urandom_range(0, 3) != 0);
      MEM_WEB = ($urandom_range(0, 4) != 0);
      MEM_CSB = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      MEM_OEB = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      MEM_ODATA_SELECT = 6'($urandom);
      SPARE_MEM_CE = ($urandom_range(0, 4) == 0);
      SPARE_MEM_WEB = ($urandom_range(0, 4) != 0);
      SPARE_MEM_CSB = 25'($urandom & $urandom);
      SPARE_MEM_OEB = 25'($urandom & $urandom);
      SPARE_MEM_ODATA_SELECT = 5'($urandom);
      ODATA_READY = ($urandom_range(0, 2) != 0);
      tick();
    end
    idle(); ODATA_READY = 1; repeat (8) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
